// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I immediate generator with valid/ready on
// both sides. Decodes the immediate format from the opcode, sign-extends to
// XLEN, flags illegal words and keeps a saturating count of the illegal
// words that are delivered downstream. SKID=1 adds a second buffer entry so
// that in_ready can come from a register and throughput stays at one per cycle.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_Z    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd6;
  localparam logic [2:0] FMT_ILL  = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_FENCE  = 7'd15;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_SYSTEM = 7'd115;

  // Decoded view of the incoming word
  logic [31:0]      w_imm32;
  logic [2:0]       w_fmt;
  logic [XLEN-1:0]  w_imm;
  logic             w_illegal;
  logic [2:0]       w_funct3;

  // Output register, skid entry and counter
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [2:0]       r_out_fmt;
  logic             r_out_illegal;
  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [2:0]       r_skid_fmt;
  logic             r_skid_illegal;
  logic [CNT_W-1:0] r_illegal_cnt;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_out_stalled;
  logic             w_skid_load;

  assign w_funct3 = in_instr[14:12];

  // Opcode decode: choose the format and assemble the 32-bit immediate
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through the case can leave a latch behind.
    w_fmt   = FMT_ILL;
    w_imm32 = '0;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
          w_fmt   = FMT_I;
          w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OP_STORE: begin
          w_fmt   = FMT_S;
          w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        OP_BRANCH: begin
          w_fmt   = FMT_B;
          w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        end
        OP_LUI, OP_AUIPC: begin
          w_fmt   = FMT_U;
          w_imm32 = {in_instr[31:12], 12'b0};
        end
        OP_JAL: begin
          w_fmt   = FMT_J;
          w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        end
        OP_SYSTEM: begin
          if (w_funct3 == 3'b100) begin
            w_fmt = FMT_ILL;
          end else if (w_funct3[2]) begin
            w_fmt   = FMT_Z;
            w_imm32 = {27'b0, in_instr[19:15]};
          end else begin
            w_fmt   = FMT_I;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
          end
        end
        OP_REG: begin
          w_fmt = FMT_NONE;
        end
        default: begin
          w_fmt = FMT_ILL;
        end
      endcase
    end
  end

  // A signed size cast replicates bit 31 up to XLEN-1 (Z-type has bit 31 clear).
  assign w_imm     = XLEN'($signed(w_imm32));
  assign w_illegal = (w_fmt == FMT_ILL);

  // Handshake. With SKID=1 in_ready is the registered skid flag; rst gates it
  // so nothing is offered while reset is held and it rises as soon as rst drops.
  assign in_ready      = !rst && ((SKID != 0) ? !r_skid_valid : (!r_out_valid || out_ready));
  assign w_in_fire     = in_valid && in_ready;
  assign w_out_fire    = r_out_valid && out_ready;
  assign w_out_stalled = r_out_valid && !out_ready;
  assign w_skid_load   = (SKID != 0) && w_in_fire && w_out_stalled;

  // Output register: load when free or draining, hand over the skid entry, hold while stalled
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register in the block sees pre-edge values.
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_imm     <= '0;
      r_out_fmt     <= FMT_NONE;
      r_out_illegal <= 1'b0;
      r_skid_valid  <= 1'b0;
    end else if (r_skid_valid) begin
      if (out_ready) begin
        r_out_imm     <= r_skid_imm;
        r_out_fmt     <= r_skid_fmt;
        r_out_illegal <= r_skid_illegal;
        r_skid_valid  <= 1'b0;
      end
    end else if (w_skid_load) begin
      r_skid_valid <= 1'b1;
    end else if (w_in_fire && !w_out_stalled) begin
      r_out_valid   <= 1'b1;
      r_out_imm     <= w_imm;
      r_out_fmt     <= w_fmt;
      r_out_illegal <= w_illegal;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // Skid payload capture
  always_ff @(posedge clk) begin
    // NOTE: the skid payload has no reset; it is only ever read while r_skid_valid, which is reset.
    if (w_skid_load) begin
      r_skid_imm     <= w_imm;
      r_skid_fmt     <= w_fmt;
      r_skid_illegal <= w_illegal;
    end
  end

  // Saturating count of illegal words that leave the block
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal_cnt <= '0;
    end else if (w_out_fire && r_out_illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_out_valid;
  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out_fmt;
  assign out_illegal = r_out_illegal;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe. Two instances share the input side:
// u_a is XLEN=32, SKID=1, CNT_W=16; u_b is XLEN=64, SKID=0, CNT_W=2.
// A table of known instruction words, hand-written backpressure and reset
// sequences, and a randomized phase, with a queue-based reference model
// checked every cycle on the falling edge.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
    .illegal_cnt(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .SKID(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
    .illegal_cnt(b_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
  } dec_t;

  function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
    logic [31:0] t;
    t = w >> lo;
    t = t & ((32'h1 << (hi - lo + 1)) - 32'h1);
    return longint'(t);
  endfunction

  // Immediate values computed arithmetically from the field definitions.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t   d;
    longint s;
    longint v;
    int     f3;
    s     = longint'($signed(ins));
    f3    = int'(ins[14:12]);
    v     = 0;
    d.fmt = 3'd7;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'd3, 7'd19, 7'd103, 7'd15: begin d.fmt = 3'd0; v = s >>> 20; end
        7'd35:  begin d.fmt = 3'd1; v = (s >>> 25) * 32 + fld(ins, 11, 7); end
        7'd99:  begin
          d.fmt = 3'd2;
          v = (s >>> 31) * 4096 + fld(ins, 7, 7) * 2048 + fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2;
        end
        7'd55, 7'd23: begin d.fmt = 3'd3; v = s - fld(ins, 11, 0); end
        7'd111: begin
          d.fmt = 3'd4;
          v = (s >>> 31) * 1048576 + fld(ins, 19, 12) * 4096 + fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2;
        end
        7'd115: begin
          if (f3 == 4)      d.fmt = 3'd7;
          else if (f3 >= 5) begin d.fmt = 3'd5; v = fld(ins, 19, 15); end
          else              begin d.fmt = 3'd0; v = s >>> 20; end
        end
        7'd51:   d.fmt = 3'd6;
        default: d.fmt = 3'd7;
      endcase
    end
    d.imm = v;
    return d;
  endfunction

  // Scoreboard: contents of each DUT as a queue, plus expected counter values.
  dec_t qa[$];
  dec_t qb[$];
  int   cnt_a = 0;
  int   cnt_b = 0;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    logic rdy_a, rdy_b, acc_a, acc_b, drn_a, drn_b;
    if (mon_en) begin
      rdy_a = !rst && (qa.size() < 2);
      rdy_b = !rst && ((qb.size() == 0) || out_ready);
      check("mon_a_in_ready", a_in_ready, rdy_a);
      check("mon_b_in_ready", b_in_ready, rdy_b);
      check("mon_a_out_valid", a_out_valid, qa.size() != 0);
      check("mon_b_out_valid", b_out_valid, qb.size() != 0);
      check("mon_a_cnt", a_cnt, cnt_a);
      check("mon_b_cnt", b_cnt, cnt_b);
      if (qa.size() != 0) begin
        check("mon_a_imm", a_out_imm, qa[0].imm[31:0]);
        check("mon_a_fmt", a_out_fmt, qa[0].fmt);
        check("mon_a_ill", a_out_illegal, qa[0].fmt == 3'd7);
      end
      if (qb.size() != 0) begin
        check("mon_b_imm", b_out_imm, qb[0].imm);
        check("mon_b_fmt", b_out_fmt, qb[0].fmt);
        check("mon_b_ill", b_out_illegal, qb[0].fmt == 3'd7);
      end
      drn_a = (qa.size() != 0) && out_ready;
      drn_b = (qb.size() != 0) && out_ready;
      acc_a = in_valid && rdy_a;
      acc_b = in_valid && rdy_b;
      if (rst) begin
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
      end else begin
        if (drn_a) begin
          if (qa[0].fmt == 3'd7 && cnt_a < 65535) cnt_a++;
          void'(qa.pop_front());
        end
        if (drn_b) begin
          if (qb[0].fmt == 3'd7 && cnt_b < 3) cnt_b++;
          void'(qb.pop_front());
        end
        if (acc_a) qa.push_back(ref_decode(in_instr));
        if (acc_b) qb.push_back(ref_decode(in_instr));
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  logic [31:0] bp_in  [4];
  logic [31:0] bp_exp [4];
  logic [6:0]  ops    [12];

  initial begin
    int idx, outi, gap;
    logic acc;
    logic [31:0] w;

    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0};
    vecs[1]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1};
    vecs[2]  = '{32'h123452B7, 64'h0000_0000_1234_5000, 3'd3};
    vecs[3]  = '{32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd4};
    vecs[4]  = '{32'h3002D073, 64'h0000_0000_0000_0005, 3'd5};
    vecs[5]  = '{32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd3};
    vecs[6]  = '{32'h00000000, 64'h0,                   3'd7};
    vecs[7]  = '{32'h0000007F, 64'h0,                   3'd7};
    vecs[8]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2};
    vecs[9]  = '{32'h002081B3, 64'h0,                   3'd6};
    vecs[10] = '{32'h00004073, 64'h0,                   3'd7};
    vecs[11] = '{32'h30029073, 64'h0000_0000_0000_0300, 3'd0};
    vecs[12] = '{32'h80002003, 64'hFFFF_FFFF_FFFF_F800, 3'd0};
    vecs[13] = '{32'h00000073, 64'h0,                   3'd0};
    vecs[14] = '{32'h00000012, 64'h0,                   3'd7};
    vecs[15] = '{32'h0000F073, 64'h0000_0000_0000_0001, 3'd5};

    bp_in[0] = 32'hFFF00093; bp_exp[0] = 32'hFFFFFFFF;
    bp_in[1] = 32'hFE112E23; bp_exp[1] = 32'hFFFFFFFC;
    bp_in[2] = 32'h123452B7; bp_exp[2] = 32'h12345000;
    bp_in[3] = 32'hFF9FF06F; bp_exp[3] = 32'hFFFFFFF8;

    ops = '{7'd3, 7'd19, 7'd103, 7'd15, 7'd35, 7'd99, 7'd55, 7'd23, 7'd111, 7'd115, 7'd51, 7'd127};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_imm",   a_out_imm,   0);
    check("rst_a_out_fmt",   a_out_fmt,   6);
    check("rst_a_out_ill",   a_out_illegal, 0);
    check("rst_a_cnt",       a_cnt,       0);
    check("rst_a_in_ready",  a_in_ready,  0);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_out_imm",   b_out_imm,   0);
    check("rst_b_out_fmt",   b_out_fmt,   6);
    check("rst_b_in_ready",  b_in_ready,  0);
    mon_en = 1'b1;
    rst = 1'b0;
    #1;
    check("post_rst_a_in_ready", a_in_ready, 1);
    check("post_rst_b_in_ready", b_in_ready, 1);

    // Table: back-to-back words, each visible one cycle after acceptance
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      tick();
      check($sformatf("vec%0d_a_valid", i), a_out_valid, 1);
      check($sformatf("vec%0d_a_imm", i),   a_out_imm,   vecs[i].imm[31:0]);
      check($sformatf("vec%0d_a_fmt", i),   a_out_fmt,   vecs[i].fmt);
      check($sformatf("vec%0d_a_ill", i),   a_out_illegal, vecs[i].fmt == 3'd7);
      check($sformatf("vec%0d_b_imm", i),   b_out_imm,   vecs[i].imm);
      check($sformatf("vec%0d_b_fmt", i),   b_out_fmt,   vecs[i].fmt);
    end
    in_valid = 1'b0;
    tick();

    // Illegal counter: reaches 2, then saturates at 3 on the CNT_W=2 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000000; tick();
    in_instr = 32'h0000007F; tick();
    check("ill_a_imm", a_out_imm, 0);
    check("ill_a_fmt", a_out_fmt, 7);
    in_valid = 1'b0; tick();
    check("ill_a_cnt2", a_cnt, 2);
    check("ill_b_cnt2", b_cnt, 2);
    in_valid = 1'b1;
    in_instr = 32'h00004073; tick();
    in_instr = 32'h00000012; tick();
    in_instr = 32'h00000000; tick();
    in_valid = 1'b0; tick();
    check("ill_a_cnt5", a_cnt, 5);
    check("ill_b_cnt_sat", b_cnt, 3);

    // Backpressure: out_ready low for 3 cycles while streaming
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_instr = bp_in[idx];
      #1;
      acc = a_in_ready;
      tick();
      if (acc) idx++;
      check("bp_hold_valid", a_out_valid, 1);
      check("bp_hold_imm", a_out_imm, bp_exp[0]);
      check("bp_hold_fmt", a_out_fmt, 0);
      if (c >= 1) check("bp_in_ready_low", a_in_ready, 0);
    end
    check("bp_accepted_while_stalled", idx, 2);
    out_ready = 1'b1;
    outi = 0;
    gap  = 0;
    for (int c = 0; c < 20 && outi < 4; c++) begin
      if (idx < 4) begin
        in_valid = 1'b1;
        in_instr = bp_in[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = a_in_ready && in_valid;
      if (a_out_valid) begin
        check($sformatf("bp_order%0d", outi), a_out_imm, bp_exp[outi]);
        outi++;
      end else begin
        gap++;
      end
      tick();
      if (acc) idx++;
    end
    check("bp_all_out", outi, 4);
    check("bp_no_gap", gap, 0);
    in_valid = 1'b0;
    tick();

    // Reset mid-stream with the output register and skid entry both full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0000007F; tick();
    in_instr  = 32'hFFF00093; tick();
    check("mid_full_valid", a_out_valid, 1);
    check("mid_full_in_ready", a_in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_rst_a_valid", a_out_valid, 0);
    check("mid_rst_a_cnt", a_cnt, 0);
    check("mid_rst_a_in_ready", a_in_ready, 1);
    check("mid_rst_b_valid", b_out_valid, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid_no_stale", a_out_valid, 0);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 11)];
      in_instr  = w;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("final_a_drained", a_out_valid, 0);
    check("final_b_drained", b_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
